// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a write-side FIFO; the first start bit appears one edge after the byte is queued.
// No backpressure to the writer: a write into a full FIFO is dropped and recorded in the sticky overflow flag.
module uart_tx #(
  parameter int P_UART_WIDTH     = 8,
  parameter int P_CLK_HZ         = 5_000_000,
  parameter int P_BAUD           = 9600,
  parameter int P_FIFO_DEPTH     = 16,
  parameter int P_FIFO_ADDR_BITS = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [P_UART_WIDTH-1:0] data_in,
  input  logic                    write_en,
  output logic                    serial_out,
  output logic                    busy,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    overflow
);

  localparam int LP_BIT_CYCLES = P_CLK_HZ / P_BAUD;
  localparam int LP_CNT_BITS   = (LP_BIT_CYCLES > 1) ? $clog2(LP_BIT_CYCLES) : 1;
  localparam int LP_IDX_BITS   = (P_UART_WIDTH > 1) ? $clog2(P_UART_WIDTH) : 1;

  localparam logic [LP_CNT_BITS-1:0]    LP_BIT_LAST = LP_CNT_BITS'(LP_BIT_CYCLES - 1);
  localparam logic [LP_IDX_BITS-1:0]    LP_IDX_LAST = LP_IDX_BITS'(P_UART_WIDTH - 1);
  localparam logic [P_FIFO_ADDR_BITS:0] LP_FULL_CNT = (P_FIFO_ADDR_BITS+1)'(P_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [P_UART_WIDTH-1:0]     mem [P_FIFO_DEPTH];
  logic [P_FIFO_ADDR_BITS-1:0] rd_ptr;
  logic [P_FIFO_ADDR_BITS-1:0] wr_ptr;
  logic [P_FIFO_ADDR_BITS:0]   count;
  logic [P_FIFO_ADDR_BITS:0]   count_nxt;
  logic [P_UART_WIDTH-1:0]     head;
  logic                        push;
  logic                        pop;

  state_t                  state;
  logic [LP_CNT_BITS-1:0]  bit_cnt;
  logic [LP_IDX_BITS-1:0]  idx;
  logic [P_UART_WIDTH-1:0] shreg;
  logic                    bit_last;

  // A full FIFO refuses the write even when the FSM pops on the same edge.
  assign push     = write_en && !fifo_full;
  assign head     = mem[rd_ptr];
  assign bit_last = (bit_cnt == LP_BIT_LAST);
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_last));

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + (P_FIFO_ADDR_BITS+1)'(1);
    end else if (!push && pop) begin
      count_nxt = count - (P_FIFO_ADDR_BITS+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + P_FIFO_ADDR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + P_FIFO_ADDR_BITS'(1);
      end
      if (write_en && fifo_full) begin
        overflow <= 1'b1;
      end
      count      <= count_nxt;
      fifo_full  <= (count_nxt == LP_FULL_CNT);
      fifo_empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      idx        <= '0;
      shreg      <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg      <= head;
            bit_cnt    <= '0;
            state      <= START;
            serial_out <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt    <= '0;
            idx        <= '0;
            state      <= DATA;
            serial_out <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + LP_CNT_BITS'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (idx == LP_IDX_LAST) begin
              state      <= STOP;
              serial_out <= 1'b1;
            end else begin
              shreg      <= shreg >> 1;
              serial_out <= shreg[1];
              idx        <= idx + LP_IDX_BITS'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + LP_CNT_BITS'(1);
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            // Chain straight into the next start bit so queued frames leave no idle gap.
            if (pop) begin
              shreg      <= head;
              state      <= START;
              serial_out <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + LP_CNT_BITS'(1);
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench: a default-rate instance for bit timing of one frame, and a fast
// instance (8 cycles per bit) for back-to-back, overflow, reset and wrap-around runs.
module tb_uart_tx;

  localparam int SB = 8;
  localparam int DB = 520;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] s_data, d_data;
  logic       s_wen, d_wen;
  logic       s_ser, s_busy, s_full, s_empty, s_ovf;
  logic       d_ser, d_busy, d_full, d_empty, d_ovf;

  int tests = 0;
  int fails = 0;
  logic [7:0] wb [5];

  always #5 CLK = ~CLK;

  uart_tx #(
    .P_UART_WIDTH(8), .P_CLK_HZ(80), .P_BAUD(10),
    .P_FIFO_DEPTH(16), .P_FIFO_ADDR_BITS(4)
  ) u_fast (
    .CLK(CLK), .reset(reset), .data_in(s_data), .write_en(s_wen),
    .serial_out(s_ser), .busy(s_busy), .fifo_full(s_full),
    .fifo_empty(s_empty), .overflow(s_ovf)
  );

  uart_tx u_dflt (
    .CLK(CLK), .reset(reset), .data_in(d_data), .write_en(d_wen),
    .serial_out(d_ser), .busy(d_busy), .fifo_full(d_full),
    .fifo_empty(d_empty), .overflow(d_ovf)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the start bit on the fast instance, then samples each bit at its centre.
  task automatic rx_byte(output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (s_ser !== 1'b0 && n < 300) begin
      tick;
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $error("FAIL rx_timeout: no start bit seen within %0d cycles", n);
      return;
    end
    repeat (SB/2) tick;
    chk("rx_start", s_ser, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (SB) tick;
      b[k] = s_ser;
    end
    repeat (SB) tick;
    chk("rx_stop", s_ser, 1'b1);
  endtask

  initial begin
    logic [9:0]  a5_seq;
    logic [19:0] b2b_seq;
    logic [7:0]  rb;
    int          bcnt;
    int          lows;

    reset  = 1'b1;
    s_wen  = 1'b0;
    s_data = '0;
    d_wen  = 1'b0;
    d_data = '0;
    tick;
    tick;
    chk("rst_serial", s_ser, 1'b1);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_empty", s_empty, 1'b1);
    chk("rst_full", s_full, 1'b0);
    chk("rst_ovf", s_ovf, 1'b0);
    chk("rst_dflt_serial", d_ser, 1'b1);
    chk("rst_dflt_full", d_full, 1'b0);
    chk("rst_dflt_ovf", d_ovf, 1'b0);
    reset = 1'b0;

    // 0xA5 at the default rate: line sequence 0,1,0,1,0,0,1,0,1,1 (index 0 = start bit).
    a5_seq = 10'b1101001010;
    d_data = 8'hA5;
    d_wen  = 1'b1;
    tick;
    chk("a5_empty_after_write", d_empty, 1'b0);
    chk("a5_busy_before_pop", d_busy, 1'b0);
    d_wen = 1'b0;
    tick;
    chk("a5_start_low", d_ser, 1'b0);
    chk("a5_busy_high", d_busy, 1'b1);
    bcnt = 0;
    for (int j = 0; j < 10*DB + 10; j++) begin
      if (d_busy) bcnt++;
      if (j % DB == DB/2) chk($sformatf("a5_bit%0d", j / DB), d_ser, a5_seq[j / DB]);
      tick;
    end
    chk("a5_busy_cycles", bcnt, 5200);
    chk("a5_idle_line", d_ser, 1'b1);
    chk("a5_idle_busy", d_busy, 1'b0);

    // 0x00 then 0xFF on consecutive edges: 20 contiguous bits, busy for 20 bit times.
    b2b_seq = 20'b1_11111111_0_1_00000000_0;
    s_data  = 8'h00;
    s_wen   = 1'b1;
    tick;
    s_data = 8'hFF;
    tick;
    s_wen = 1'b0;
    bcnt  = 0;
    for (int j = 0; j < 20*SB + 10; j++) begin
      if (s_busy) bcnt++;
      if (j % SB == SB/2 && j / SB < 20) chk($sformatf("b2b_bit%0d", j / SB), s_ser, b2b_seq[j / SB]);
      tick;
    end
    chk("b2b_busy_cycles", bcnt, 20*SB);
    chk("b2b_empty", s_empty, 1'b1);

    // 18 writes: first is popped at once, next 16 fill the FIFO, the 18th is dropped.
    fork
      begin
        for (int i = 1; i <= 18; i++) begin
          s_data = 8'(i);
          s_wen  = 1'b1;
          tick;
          if (i == 17) begin
            chk("ovf_full_at_17", s_full, 1'b1);
            chk("ovf_clear_at_17", s_ovf, 1'b0);
          end
          if (i == 18) begin
            chk("ovf_set_at_18", s_ovf, 1'b1);
            chk("ovf_full_at_18", s_full, 1'b1);
          end
        end
        s_wen = 1'b0;
      end
      begin
        for (int i = 1; i <= 17; i++) begin
          rx_byte(rb);
          chk($sformatf("ovf_byte%0d", i), rb, 8'(i));
        end
      end
    join
    repeat (SB) tick;
    chk("ovf_drained_busy", s_busy, 1'b0);
    chk("ovf_drained_empty", s_empty, 1'b1);
    chk("ovf_sticky", s_ovf, 1'b1);

    // Reset during data bit 3 of 0x3C with three bytes still queued.
    for (int i = 0; i < 4; i++) begin
      s_data = (i == 0) ? 8'h3C : 8'(8'h51 + i);
      s_wen  = 1'b1;
      tick;
    end
    s_wen = 1'b0;
    repeat (34) tick;
    chk("rstmid_bit3", s_ser, 1'b1);
    chk("rstmid_queued", s_empty, 1'b0);
    reset = 1'b1;
    tick;
    chk("rstmid_serial", s_ser, 1'b1);
    chk("rstmid_busy", s_busy, 1'b0);
    chk("rstmid_empty", s_empty, 1'b1);
    chk("rstmid_full", s_full, 1'b0);
    chk("rstmid_ovf", s_ovf, 1'b0);
    reset = 1'b0;
    lows  = 0;
    for (int j = 0; j < 300; j++) begin
      if (s_ser !== 1'b1 || s_busy !== 1'b0) lows++;
      tick;
    end
    chk("rstmid_silent_cycles", lows, 0);

    // 40 rounds of 5 bytes: 200 bytes through a 16-entry ring.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 5; i++) wb[i] = 8'($urandom_range(0, 255));
      fork
        begin
          for (int i = 0; i < 5; i++) begin
            s_data = wb[i];
            s_wen  = 1'b1;
            tick;
          end
          s_wen = 1'b0;
        end
        begin
          for (int i = 0; i < 5; i++) begin
            rx_byte(rb);
            chk($sformatf("wrap_r%0d_b%0d", r, i), rb, wb[i]);
          end
        end
      join
      repeat (SB) tick;
    end
    chk("wrap_ovf", s_ovf, 1'b0);
    chk("wrap_empty", s_empty, 1'b1);
    chk("wrap_busy", s_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter with a write-side FIFO. It is the stage directly upstream of `uart_rx`: it accepts parallel bytes from the system, buffers them, and drives the 8N1 serial line that `uart_rx` samples on `serial_in`. The bit timing is derived from the system clock with the same clock-to-baud ratio `uart_rx` uses, so the two blocks can be looped back directly in the bench.

## Interface
- `P_UART_WIDTH`, 8: data bits per frame.
- `P_CLK_HZ`, 5_000_000: system clock frequency.
- `P_BAUD`, 9600: line rate.
- `P_FIFO_DEPTH`, 16: FIFO entries; must be a power of two.
- `P_FIFO_ADDR_BITS`, 4: log2(`P_FIFO_DEPTH`).
- Derived: `LP_BIT_CYCLES` = `P_CLK_HZ / P_BAUD`, using integer division. The default value is 520.

Ports:
- `CLK`  in  1  system clock. This is the only clock. All logic is on the rising edge.
- `reset`  in  1  reset. It is synchronous and active-high.
- `data_in`  in  `P_UART_WIDTH`  byte to enqueue.
- `write_en`  in  1  enqueue request, sampled on every rising edge.
- `serial_out`  out  1  UART line. It idles high.
- `busy`  out  1  high while a frame (start, data or stop bit) is on the line.
- `fifo_full`  out  1  FIFO holds `P_FIFO_DEPTH` entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  sticky flag: a write was dropped. It is cleared only by `reset`.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers of `P_FIFO_ADDR_BITS` bits each, wrapping naturally.
  - A count of `P_FIFO_ADDR_BITS+1` bits drives `fifo_full` and `fifo_empty`. Both flags are registered and reflect the count after each edge.
- **Push rule**
  - A push happens when `write_en` is high and `fifo_full` is low.
  - When `write_en` is high and `fifo_full` is high, the byte is dropped and `overflow` is set. This holds even if a pop happens on the same edge: a full FIFO rejects the push.
- **Pop rule**
  - Pops are issued by the FSM only, and only when `fifo_empty` is low.
  - A simultaneous push and pop leaves the count unchanged.
  - There is no bypass: a byte pushed into an empty FIFO is popped no earlier than the next edge.
- **FSM states:** IDLE, START, DATA, STOP. A bit counter counts cycles 0..`LP_BIT_CYCLES`-1. An index counter counts data bits 0..`P_UART_WIDTH`-1.
- **IDLE**
  - `serial_out`=1, `busy`=0.
  - If `fifo_empty`=0: pop the head into the shift register, clear the bit counter, go to START.
- **START**
  - `serial_out`=0 for `LP_BIT_CYCLES` cycles, then go to DATA.
- **DATA**
  - `serial_out` = shift register bit 0, sent LSB first.
  - Each bit is held `LP_BIT_CYCLES` cycles, then the register shifts right.
  - After bit `P_UART_WIDTH`-1, go to STOP.
- **STOP**
  - `serial_out`=1 for `LP_BIT_CYCLES` cycles.
  - On the last STOP cycle, if `fifo_empty`=0: pop and go directly to START, so frames are back-to-back with no idle gap.
  - Otherwise go to IDLE.
- **Reset values:** `serial_out`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0; state IDLE; pointers, count and counters at 0.
- **Reset mid-frame:** the frame is aborted and the line returns high on the next edge. FIFO contents are discarded.

## Timing
- **Write latency:** `write_en` high at edge t into an idle, empty block:
  - after edge t: `fifo_empty`=0;
  - at edge t+1: pop;
  - after edge t+1: `serial_out`=0 and `busy`=1.
- **Frame length:** exactly 10×`LP_BIT_CYCLES` cycles per byte (start + 8 data + stop). With the defaults this is 5200 cycles.
- **Back-to-back frames:** start bit k+1 begins on the edge immediately after the last stop cycle of frame k.
- **`busy` timing:** `busy` falls on the same edge that `serial_out` enters IDLE.
- **Throughput:** 1 byte per frame. Up to `P_FIFO_DEPTH`+1 bytes can be accepted in consecutive cycles, because the first is popped immediately.

## Test plan
- **Single byte, default parameters:** write 0xA5, then sample `serial_out` at the mid-point of each bit -> bit sequence 0,1,0,1,0,0,1,0,1,1. `busy` is high for exactly 5200 cycles.
- **Back-to-back frames:** write 0x00 then 0xFF on consecutive edges -> 20 contiguous bits (start, 8 zeros, stop, start, 8 ones, stop) with no high gap between the two frames. `busy` stays high for 10400 cycles.
- **Overflow:** write 18 consecutive bytes 0x01..0x12 into an idle block:
  - 0x01..0x11 are accepted;
  - 0x12 is dropped;
  - `overflow`=1 and `fifo_full`=1 on the edge after the 18th write;
  - the line then carries 0x01..0x11 in order.
- **Loopback to `uart_rx`:** `serial_out` drives `serial_in`. Send 15 random bytes, then pulse `display_next` 15 times -> `{data_out_msd,data_out_lsd}` matches each byte in order, with `error`=0.
- **Reset mid-frame:** assert `reset` for 1 cycle during data bit 3 of a frame, with 3 more bytes queued:
  - after the edge: `serial_out`=1, `busy`=0, `fifo_empty`=1, `overflow`=0;
  - no further frames are sent.
- **Wrap-around:** run 40 write/transmit cycles of 5 bytes each, so the pointers wrap several times -> every byte arrives in order and `overflow` stays 0.
